// File: rtl/vadd_seq.sv
// vadd_seq: sequential half-precision vector adder. One shared FADD processes
//   lane 0..vlen in turn, one lane per clock. Latency: done is high vlen+2 cycles after start.
// Flow control: start is taken only in IDLE or DONE and is ignored while busy.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start             begin an operation (sampled in IDLE/DONE only)
//   vlen[3:0]         active lanes minus one, latched with start
//   a, b [LANES*W]    operand vectors, lane i at [W*i +: W], latched with start
//   sum  [LANES*W]    registered result; lanes above vlen read zero
//   busy              high while lanes are being processed (RUN)
//   done              one-cycle pulse when sum/g_flag_op are final
//   g_flag_op         OR of the adder flag over all active lanes

// fadd: combinational IEEE-754 binary16 adder, round-to-nearest-even.
//   Latency: none (pure combinational).
// Flow control: not applicable. flag marks overflow to infinity or an invalid inf-inf.
//
// Ports: a, b operands; sum result; flag overflow/invalid indication.
module fadd (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        flag
);

    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_swap;
    logic [15:0] w_x;       // larger magnitude operand
    logic [15:0] w_y;       // smaller magnitude operand
    logic [5:0]  w_ex;
    logic [5:0]  w_ey;
    logic [5:0]  w_d;
    logic [10:0] w_mx;
    logic [10:0] w_my;
    logic [27:0] w_shift;
    logic [13:0] w_al;
    logic        w_st;
    logic        w_sub;
    logic [14:0] w_s;
    logic [3:0]  w_lz;
    logic [5:0]  w_sh;
    logic [5:0]  w_en;
    logic [5:0]  w_ef;
    logic [13:0] w_n;
    logic        w_rup;
    logic [11:0] w_m12;
    logic [9:0]  w_fr;

    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] r;
        r = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (v[i]) r = 4'(13 - i);
        end
        return r;
    endfunction

    assign w_a_nan = (&a[14:10]) & (|a[9:0]);
    assign w_b_nan = (&b[14:10]) & (|b[9:0]);
    assign w_a_inf = (&a[14:10]) & ~(|a[9:0]);
    assign w_b_inf = (&b[14:10]) & ~(|b[9:0]);

    // Order by magnitude so the aligned subtraction never goes negative and
    // the result sign is simply the sign of the larger operand.
    assign w_swap = (b[14:0] > a[14:0]);
    assign w_x    = w_swap ? b : a;
    assign w_y    = w_swap ? a : b;

    // Subnormals share the exponent of the smallest normal (1) with no hidden bit.
    assign w_ex  = (w_x[14:10] == 5'd0) ? 6'd1 : {1'b0, w_x[14:10]};
    assign w_ey  = (w_y[14:10] == 5'd0) ? 6'd1 : {1'b0, w_y[14:10]};
    assign w_mx  = {|w_x[14:10], w_x[9:0]};
    assign w_my  = {|w_y[14:10], w_y[9:0]};
    assign w_d   = w_ex - w_ey;
    assign w_sub = w_x[15] ^ w_y[15];

    // Alignment keeps guard/round bits plus a sticky bit folded into the LSB;
    // that is enough information for correct nearest-even rounding.
    always_comb begin
        w_shift = {w_my, 17'd0} >> w_d;
        if (w_d >= 6'd14) begin
            w_al = '0;
            w_st = |w_my;
        end else begin
            w_al = w_shift[27:14];
            w_st = |w_shift[13:0];
        end
    end

    assign w_s = w_sub ? ({1'b0, w_mx, 3'b000} - {1'b0, w_al[13:1], w_al[0] | w_st})
                       : ({1'b0, w_mx, 3'b000} + {1'b0, w_al[13:1], w_al[0] | w_st});

    // Normalise: carry-out shifts right one place; cancellation shifts left,
    // but never below exponent 1 so tiny results become subnormal.
    always_comb begin
        w_lz = lzc14(w_s[13:0]);
        w_sh = '0;
        if (w_s[14]) begin
            w_n  = {w_s[14:2], w_s[1] | w_s[0]};
            w_en = w_ex + 6'd1;
        end else begin
            w_sh = ({2'b00, w_lz} > (w_ex - 6'd1)) ? (w_ex - 6'd1) : {2'b00, w_lz};
            w_n  = w_s[13:0] << w_sh;
            w_en = w_ex - w_sh;
        end
    end

    // Round to nearest even; a mantissa carry bumps the exponent, and a
    // subnormal that rounds up into the hidden bit becomes exponent 1.
    always_comb begin
        w_rup = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
        w_m12 = {1'b0, w_n[13:3]} + {11'd0, w_rup};
        if (w_m12[11]) begin
            w_ef = w_en + 6'd1;
            w_fr = w_m12[10:1];
        end else if (w_m12[10]) begin
            w_ef = w_en;
            w_fr = w_m12[9:0];
        end else begin
            w_ef = 6'd0;
            w_fr = w_m12[9:0];
        end
    end

    always_comb begin
        sum  = {w_x[15], w_ef[4:0], w_fr};
        flag = 1'b0;
        if (w_a_nan || w_b_nan) begin
            sum = 16'h7E00;
        end else if (w_a_inf && w_b_inf && (a[15] != b[15])) begin
            sum  = 16'h7E00;
            flag = 1'b1;
        end else if (w_a_inf) begin
            sum = a;
        end else if (w_b_inf) begin
            sum = b;
        end else if (w_s == 15'd0) begin
            // Exact zero is +0 unless both inputs were -0.
            sum = {a[15] & b[15], 15'd0};
        end else if (w_ef >= 6'd31) begin
            sum  = {w_x[15], 5'h1F, 10'd0};
            flag = 1'b1;
        end
    end

endmodule

module vadd_seq #(
    parameter int LANES = 16,
    parameter int W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         vlen,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    output logic [LANES*W-1:0] sum,
    output logic               busy,
    output logic               done,
    output logic               g_flag_op
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_last;
    logic [LANES*W-1:0] r_a;
    logic [LANES*W-1:0] r_b;
    logic [3:0]         r_vlen;
    logic [3:0]         r_idx;
    logic [LANES*W-1:0] r_sum;
    logic               r_flag;
    logic [W-1:0]       w_op_a;
    logic [W-1:0]       w_op_b;
    logic [15:0]        w_fadd_sum;
    logic               w_fadd_flag;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_idx == r_vlen);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_last)   w_next = S_DONE;
            S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // Lane select feeding the single shared adder.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_idx == 4'(i)) begin
                w_op_a = r_a[i*W +: W];
                w_op_b = r_b[i*W +: W];
            end
        end
    end

    fadd u_fadd (
        .a    (w_op_a),
        .b    (w_op_b),
        .sum  (w_fadd_sum),
        .flag (w_fadd_flag)
    );

    // Datapath. Clearing sum on accept is what makes inactive lanes read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_vlen <= '0;
            r_idx  <= '0;
            r_sum  <= '0;
            r_flag <= 1'b0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_vlen <= vlen;
            r_idx  <= '0;
            r_sum  <= '0;
            r_flag <= 1'b0;
        end else if (r_state == S_RUN) begin
            for (int i = 0; i < LANES; i++) begin
                if (r_idx == 4'(i)) r_sum[i*W +: W] <= w_fadd_sum;
            end
            r_flag <= r_flag | w_fadd_flag;
            // Hold at the last lane so the 4-bit index never wraps.
            if (!w_last) r_idx <= r_idx + 4'd1;
        end
    end

    assign sum       = r_sum;
    assign g_flag_op = r_flag;

endmodule

// File: tb/tb_vadd_seq.sv
module tb_vadd_seq;

    localparam int LANES = 16;
    localparam int W     = 16;
    typedef logic [LANES*W-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] vlen = '0;
    vec_t       a = '0;
    vec_t       b = '0;
    vec_t       sum;
    logic       busy;
    logic       done;
    logic       g_flag_op;

    int total = 0;
    int bad   = 0;

    vadd_seq #(.LANES(LANES), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vlen      (vlen),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .busy      (busy),
        .done      (done),
        .g_flag_op (g_flag_op)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (real arithmetic) ----------------
    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else        repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real m;
        if (h[14:10] == 5'd0) m = real'(h[9:0]) * pow2(-24);
        else                  m = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -m : m;
    endfunction

    function automatic int flog2(input real v);
        int  e;
        real p;
        e = 0;
        p = 1.0;
        while (p * 2.0 <= v) begin p = p * 2.0; e++; end
        while (p > v)        begin p = p / 2.0; e--; end
        return e;
    endfunction

    // Finite operands only: exact real sum, then round-to-nearest-even into binary16.
    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y);
        real s, ax, q, m, fl, fr, rr;
        int  e, qe, e2;
        logic sg;
        logic [15:0] r;
        s = h2r(x) + h2r(y);
        if (s == 0.0) return {1'b0, x[15] & y[15], 15'd0};
        sg = (s < 0.0);
        ax = sg ? -s : s;
        e  = flog2(ax);
        qe = ((e < -14) ? -14 : e) - 10;
        q  = pow2(qe);
        m  = ax / q;
        fl = $floor(m);
        fr = m - fl;
        if (fr > 0.5 || (fr == 0.5 && ($rtoi(fl) % 2) == 1)) fl = fl + 1.0;
        rr = fl * q;
        if (rr >= 65536.0) return {1'b1, sg, 5'h1F, 10'd0};
        if (rr < pow2(-14)) begin
            r = {sg, 5'd0, 10'($rtoi(fl))};
        end else begin
            e2 = flog2(rr);
            r  = {sg, 5'(e2 + 15), 10'($rtoi(rr / pow2(e2 - 10)) - 1024)};
        end
        return {1'b0, r};
    endfunction

    function automatic void model_op(input vec_t va, input vec_t vb, input logic [3:0] vl,
                                     output vec_t s, output logic f);
        logic [16:0] r;
        s = '0;
        f = 1'b0;
        for (int i = 0; i <= int'(vl); i++) begin
            r = ref_add(va[i*W +: W], vb[i*W +: W]);
            s[i*W +: W] = r[15:0];
            f = f | r[16];
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < LANES*W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h[15]    = 1'($urandom_range(0, 1));
        h[14:10] = 5'($urandom_range(0, 30));
        h[9:0]   = 10'($urandom);
        if ($urandom_range(0, 7) == 0) h[14:0] = '0;
        return h;
    endfunction

    task automatic gen_pair(output vec_t va, output vec_t vb);
        logic [15:0] x, y;
        for (int i = 0; i < LANES; i++) begin
            x = rand_half();
            case ($urandom_range(0, 3))
                0:       y = x ^ 16'h8000;
                1:       y = {~x[15], x[14:10], 10'($urandom)};
                default: y = rand_half();
            endcase
            va[i*W +: W] = x;
            vb[i*W +: W] = y;
        end
    endtask

    // Starts one operation (called just after a falling edge), scrambles the
    // inputs after the start cycle, and reports the cycle done was seen in.
    task automatic do_op(input vec_t va, input vec_t vb, input logic [3:0] vl,
                         output int lat, output vec_t s, output logic f, output int nbusy);
        start = 1'b1;
        a = va;
        b = vb;
        vlen = vl;
        @(negedge clk);
        start = 1'b0;
        a = rand_vec();
        b = rand_vec();
        vlen = 4'($urandom);
        lat = -1;
        nbusy = 0;
        s = '0;
        f = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            if (busy) nbusy++;
            if (done) begin
                lat = c;
                s = sum;
                f = g_flag_op;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum: got %h want 0", sum); end
        total++; if (g_flag_op !== 1'b0) begin bad++; $display("FAIL reset_flag: got %b want 0", g_flag_op); end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_start_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_vector();
        vec_t s, exp_s;
        logic f;
        int lat, nb;
        exp_s = {LANES{16'h4000}};
        do_op({LANES{16'h3C00}}, {LANES{16'h3C00}}, 4'd15, lat, s, f, nb);
        total++; if (lat !== 17) begin bad++; $display("FAIL full_latency: got %0d want 17", lat); end
        total++; if (nb !== 16) begin bad++; $display("FAIL full_busy_cycles: got %0d want 16", nb); end
        total++; if (s !== exp_s) begin bad++; $display("FAIL full_sum: got %h want %h", s, exp_s); end
        total++; if (f !== 1'b0) begin bad++; $display("FAIL full_flag: got %b want 0", f); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL full_done_one_cycle: got %b want 0", done); end
        total++; if (sum !== exp_s) begin bad++; $display("FAIL full_sum_hold: got %h want %h", sum, exp_s); end
    endtask

    task automatic test_partial();
        vec_t s, exp_s;
        logic f;
        int lat, nb;
        exp_s = '0;
        exp_s[47:0] = {3{16'h4200}};
        do_op({LANES{16'h3C00}}, {LANES{16'h4000}}, 4'd2, lat, s, f, nb);
        total++; if (lat !== 4) begin bad++; $display("FAIL partial_latency: got %0d want 4", lat); end
        total++; if (s !== exp_s) begin bad++; $display("FAIL partial_sum: got %h want %h", s, exp_s); end
        total++; if (nb !== 3) begin bad++; $display("FAIL partial_busy_cycles: got %0d want 3", nb); end
        @(negedge clk);
    endtask

    task automatic test_flag();
        vec_t va, s, exp_s;
        logic f;
        int lat, nb;
        va = '0;
        va[7*W +: W] = 16'h7BFF;
        exp_s = '0;
        exp_s[7*W +: W] = 16'h7C00;
        do_op(va, va, 4'd15, lat, s, f, nb);
        total++; if (f !== 1'b1) begin bad++; $display("FAIL flag_set: got %b want 1", f); end
        total++; if (s !== exp_s) begin bad++; $display("FAIL flag_sum: got %h want %h", s, exp_s); end
        total++; if (lat !== 17) begin bad++; $display("FAIL flag_latency: got %0d want 17", lat); end
        @(negedge clk);
        do_op('0, '0, 4'd15, lat, s, f, nb);
        total++; if (f !== 1'b0) begin bad++; $display("FAIL flag_cleared: got %b want 0", f); end
        total++; if (s !== '0) begin bad++; $display("FAIL flag_rerun_sum: got %h want 0", s); end
        @(negedge clk);
    endtask

    task automatic test_start_in_run();
        vec_t va, vb, exp_s, s;
        logic exp_f, f;
        int lat;
        gen_pair(va, vb);
        model_op(va, vb, 4'd15, exp_s, exp_f);
        start = 1'b1;
        a = va;
        b = vb;
        vlen = 4'd15;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        s = '0;
        f = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                lat = c;
                s = sum;
                f = g_flag_op;
                break;
            end
            start = (c == 5);
            if (c == 5) begin
                a = rand_vec();
                b = rand_vec();
                vlen = 4'd3;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (lat !== 17) begin bad++; $display("FAIL run_start_latency: got %0d want 17", lat); end
        total++; if (s !== exp_s) begin bad++; $display("FAIL run_start_sum: got %h want %h", s, exp_s); end
        total++; if (f !== exp_f) begin bad++; $display("FAIL run_start_flag: got %b want %b", f, exp_f); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_run();
        vec_t va, vb, exp_s, s;
        logic exp_f, f;
        int lat, nb, npulse;
        va = {LANES{16'h3C00}};
        vb = {LANES{16'h3C00}};
        start = 1'b1;
        a = va;
        b = vb;
        vlen = 4'd15;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 3; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (sum !== '0) begin bad++; $display("FAIL abort_sum: got %h want 0", sum); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
        npulse = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) npulse++;
            @(negedge clk);
        end
        total++; if (npulse !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", npulse); end
        gen_pair(va, vb);
        model_op(va, vb, 4'd6, exp_s, exp_f);
        do_op(va, vb, 4'd6, lat, s, f, nb);
        total++; if (lat !== 8) begin bad++; $display("FAIL after_abort_latency: got %0d want 8", lat); end
        total++; if (s !== exp_s) begin bad++; $display("FAIL after_abort_sum: got %h want %h", s, exp_s); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        vec_t va1, vb1, va2, vb2, e1, e2, s1, s2;
        logic f1e, f2e;
        int lat1, lat2, nd;
        gen_pair(va1, vb1);
        gen_pair(va2, vb2);
        model_op(va1, vb1, 4'd5, e1, f1e);
        model_op(va2, vb2, 4'd8, e2, f2e);
        lat1 = -10;
        lat2 = -1;
        nd = 0;
        s1 = '0;
        s2 = '0;
        start = 1'b1;
        a = va1;
        b = vb1;
        vlen = 4'd5;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (nd == 1 && c == lat1 + 1) begin
                start = 1'b0;
                a = rand_vec();
                b = rand_vec();
                vlen = 4'($urandom);
            end
            if (done) begin
                nd++;
                if (nd == 1) begin
                    lat1 = c;
                    s1 = sum;
                    a = va2;
                    b = vb2;
                    vlen = 4'd8;
                end else begin
                    lat2 = c;
                    s2 = sum;
                end
            end
        end
        start = 1'b0;
        total++; if (nd !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
        total++; if (lat1 !== 7) begin bad++; $display("FAIL b2b_latency1: got %0d want 7", lat1); end
        total++; if (lat2 !== 17) begin bad++; $display("FAIL b2b_latency2: got %0d want 17", lat2); end
        total++; if (s1 !== e1) begin bad++; $display("FAIL b2b_sum1: got %h want %h", s1, e1); end
        total++; if (s2 !== e2) begin bad++; $display("FAIL b2b_sum2: got %h want %h", s2, e2); end
    endtask

    task automatic test_random();
        vec_t va, vb, exp_s, s;
        logic exp_f, f;
        logic [3:0] vl;
        int lat, nb;
        for (int n = 0; n < 30; n++) begin
            gen_pair(va, vb);
            vl = 4'($urandom);
            model_op(va, vb, vl, exp_s, exp_f);
            do_op(va, vb, vl, lat, s, f, nb);
            total++; if (lat !== int'(vl) + 2) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, int'(vl) + 2); end
            total++; if (s !== exp_s) begin bad++; $display("FAIL rand_sum[%0d]: got %h want %h", n, s, exp_s); end
            total++; if (f !== exp_f) begin bad++; $display("FAIL rand_flag[%0d]: got %b want %b", n, f, exp_f); end
            total++; if (nb !== int'(vl) + 1) begin bad++; $display("FAIL rand_busy[%0d]: got %0d want %0d", n, nb, int'(vl) + 1); end
            @(negedge clk);
            total++; if (done !== 1'b0) begin bad++; $display("FAIL rand_done_pulse[%0d]: got %b want 0", n, done); end
            total++; if (sum !== exp_s) begin bad++; $display("FAIL rand_sum_hold[%0d]: got %h want %h", n, sum, exp_s); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_vector();
        test_partial();
        test_flag();
        test_start_in_run();
        test_reset_in_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
